// File: rtl/reg_file_zero_bypass_pkg.sv
// Shared constants and the byte-lane merge helper for the register file.
package regfile_pkg;

   localparam int unsigned REG_ZERO       = 0;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_NUM_REGS   = 32;

   // Widest word merge_bytes handles; callers zero-extend and truncate around it.
   localparam int unsigned MAX_DATA_WIDTH = 512;
   localparam int unsigned MAX_BYTES      = MAX_DATA_WIDTH / 8;

   function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_BYTES-1:0]      be
   );
      logic [MAX_DATA_WIDTH-1:0] res;
      res = old_word;
      for (int unsigned i = 0; i < MAX_BYTES; i++) begin
         if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/reg_file_zero_bypass_if.sv
// Read/write bus of the register file: two read ports and one byte-enabled write port.
interface reg_file_zero_bypass_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
);

   logic                    ren_a;
   logic [ADDR_WIDTH-1:0]   addr_a;
   logic [DATA_WIDTH-1:0]   dout_a;
   logic                    rvalid_a;
   logic                    ren_b;
   logic [ADDR_WIDTH-1:0]   addr_b;
   logic [DATA_WIDTH-1:0]   dout_b;
   logic                    rvalid_b;
   logic                    we;
   logic [ADDR_WIDTH-1:0]   waddr;
   logic [DATA_WIDTH-1:0]   din;
   logic [DATA_WIDTH/8-1:0] wbe;

   modport master (
      output ren_a, addr_a, ren_b, addr_b, we, waddr, din, wbe,
      input  dout_a, rvalid_a, dout_b, rvalid_b
   );

   modport slave (
      input  ren_a, addr_a, ren_b, addr_b, we, waddr, din, wbe,
      output dout_a, rvalid_a, dout_b, rvalid_b
   );

endinterface

// File: rtl/reg_file_zero_bypass_read_port.sv
// One registered read port: zero/out-of-range masking, optional write bypass, output register.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
   parameter int unsigned ZERO_REG   = 1,
   parameter int unsigned BYPASS     = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ren,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   mem [NUM_REGS],
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]   din,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   output logic [DATA_WIDTH-1:0]   dout,
   output logic                    rvalid
);

   logic                  in_range;
   logic                  is_zero;
   logic                  hit;
   logic [DATA_WIDTH-1:0] stored;
   logic [DATA_WIDTH-1:0] dout_d;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  rvalid_q;

   always_comb begin
      in_range = 32'(addr) < NUM_REGS;
      is_zero  = (ZERO_REG != 0) && (32'(addr) == REG_ZERO);
      stored   = (in_range && !is_zero) ? mem[addr] : '0;
      // wr_en is already qualified, so a hit never lands on a dropped write or on r0.
      hit      = (BYPASS != 0) && wr_en && (addr == waddr);
      dout_d   = stored;
      if (hit) begin
         dout_d = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(stored), MAX_DATA_WIDTH'(din),
                                          MAX_BYTES'(wbe)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= ren;
         if (ren) dout_q <= dout_d;
      end
   end

   assign dout   = dout_q;
   assign rvalid = rvalid_q;

endmodule

// File: rtl/reg_file_zero_bypass.sv
// General-purpose register file with optional hardwired-zero r0 and write-to-read bypass.
module reg_file_zero_bypass
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
   parameter int unsigned ZERO_REG   = 1,
   parameter int unsigned BYPASS     = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   reg_file_zero_bypass_if.slave bus
);

   logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_word;

   always_comb begin
      wr_en = bus.we && (|bus.wbe) && (32'(bus.waddr) < NUM_REGS)
              && !((ZERO_REG != 0) && (32'(bus.waddr) == REG_ZERO));
      wr_word = '0;
      if (wr_en) begin
         wr_word = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(mem_q[bus.waddr]),
                                           MAX_DATA_WIDTH'(bus.din), MAX_BYTES'(bus.wbe)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[bus.waddr] <= wr_word;
      end
   end

   regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
   ) u_port_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .ren    (bus.ren_a),
      .addr   (bus.addr_a),
      .mem    (mem_q),
      .wr_en  (wr_en),
      .waddr  (bus.waddr),
      .din    (bus.din),
      .wbe    (bus.wbe),
      .dout   (bus.dout_a),
      .rvalid (bus.rvalid_a)
   );

   regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
   ) u_port_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .ren    (bus.ren_b),
      .addr   (bus.addr_b),
      .mem    (mem_q),
      .wr_en  (wr_en),
      .waddr  (bus.waddr),
      .din    (bus.din),
      .wbe    (bus.wbe),
      .dout   (bus.dout_b),
      .rvalid (bus.rvalid_b)
   );

endmodule

// File: tb/tb_reg_file_zero_bypass.sv
// Scoreboard bench: two configurations (32 regs/zero/bypass and 24 regs/plain/no bypass).
module tb_reg_file_zero_bypass;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_file_zero_bypass_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if0 ();
   reg_file_zero_bypass_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if1 ();

   reg_file_zero_bypass #(
      .DATA_WIDTH (32),
      .NUM_REGS   (32),
      .ZERO_REG   (1),
      .BYPASS     (1)
   ) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0)
   );

   reg_file_zero_bypass #(
      .DATA_WIDTH (32),
      .NUM_REGS   (24),
      .ZERO_REG   (0),
      .BYPASS     (0)
   ) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   int unsigned cfg_nregs [2] = '{32, 24};
   bit          cfg_zr    [2] = '{1'b1, 1'b0};
   bit          cfg_byp   [2] = '{1'b1, 1'b0};

   logic [31:0] mdl [2][32];
   logic [31:0] expq [4][$];
   logic [31:0] held [4];
   int          checks = 0;
   int          failures = 0;
   bit          checking = 1'b0;

   // Port index p = 2*config + (0 for A, 1 for B).
   wire [31:0] dv [4];
   wire        rv [4];
   assign dv[0] = if0.dout_a;
   assign dv[1] = if0.dout_b;
   assign dv[2] = if1.dout_a;
   assign dv[3] = if1.dout_b;
   assign rv[0] = if0.rvalid_a;
   assign rv[1] = if0.rvalid_b;
   assign rv[2] = if1.rvalid_a;
   assign rv[3] = if1.rvalid_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_value(input int d, input int a);
      if (a >= int'(cfg_nregs[d]) || (cfg_zr[d] && a == 0)) return 32'h0;
      return mdl[d][a];
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   task automatic set_inputs(input bit ra, input int aa, input bit rb, input int ab, input bit we,
                             input int wa, input logic [31:0] din, input logic [3:0] wbe);
      if0.ren_a = ra; if0.addr_a = 5'(aa); if0.ren_b = rb; if0.addr_b = 5'(ab);
      if0.we = we; if0.waddr = 5'(wa); if0.din = din; if0.wbe = wbe;
      if1.ren_a = ra; if1.addr_a = 5'(aa); if1.ren_b = rb; if1.addr_b = 5'(ab);
      if1.we = we; if1.waddr = 5'(wa); if1.din = din; if1.wbe = wbe;
   endtask

   task automatic drive(input bit ra, input int aa, input bit rb, input int ab, input bit we,
                        input int wa, input logic [31:0] din, input logic [3:0] wbe);
      @(negedge clk);
      set_inputs(ra, aa, rb, ab, we, wa, din, wbe);
      for (int d = 0; d < 2; d++) begin
         bit          wok;
         logic [31:0] post;
         wok  = we && (wbe != 4'h0) && wa < int'(cfg_nregs[d]) && !(cfg_zr[d] && wa == 0);
         post = wok ? lane_merge(model_value(d, wa), din, wbe) : 32'h0;
         if (ra) expq[2*d].push_back((cfg_byp[d] && wok && aa == wa) ? post : model_value(d, aa));
         if (rb) expq[2*d+1].push_back((cfg_byp[d] && wok && ab == wa) ? post : model_value(d, ab));
         if (wok) mdl[d][wa] = post;
      end
   endtask

   task automatic idle();
      drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 32'h0, 4'h0);
   endtask

   task automatic clear_model();
      for (int p = 0; p < 4; p++) begin
         expq[p].delete();
         held[p] = 32'h0;
      end
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 32; a++) mdl[d][a] = 32'h0;
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("%s dout p%0d", tag, p), dv[p], 32'h0);
         chk($sformatf("%s rvalid p%0d", tag, p), 32'(rv[p]), 32'h0);
      end
   endtask

   // Reset lands mid-cycle with a read and a write already presented; both must be lost.
   task automatic reset_mid();
      @(negedge clk);
      set_inputs(1'b1, 5, 1'b1, 5, 1'b1, 6, 32'hFFFF_FFFF, 4'hF);
      #3;
      rst_n = 1'b0;
      checking = 1'b0;
      #1;
      check_reset_outputs("async reset");
      clear_model();
      @(negedge clk);
      set_inputs(1'b0, 0, 1'b0, 0, 1'b0, 0, 32'h0, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      checking = 1'b1;
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #2;
         if (checking) begin
            for (int p = 0; p < 4; p++) begin
               if (rv[p]) begin
                  if (expq[p].size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected rvalid p%0d: got dout 0x%08h expected no read",
                              p, dv[p]);
                  end else begin
                     logic [31:0] e;
                     e = expq[p].pop_front();
                     chk($sformatf("read p%0d", p), dv[p], e);
                     held[p] = e;
                  end
               end else begin
                  chk($sformatf("hold p%0d", p), dv[p], held[p]);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      clear_model();
      set_inputs(1'b0, 0, 1'b0, 0, 1'b0, 0, 32'h0, 4'h0);
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("power-on reset");
      rst_n = 1'b1;
      checking = 1'b1;

      // Data written before an asynchronous reset must not survive it.
      drive(1'b0, 0, 1'b0, 0, 1'b1, 5, 32'hDEAD_BEEF, 4'hF);
      drive(1'b1, 5, 1'b1, 5, 1'b0, 0, 32'h0, 4'h0);
      idle();
      reset_mid();
      drive(1'b1, 5, 1'b1, 6, 1'b0, 0, 32'h0, 4'h0);
      idle();

      // r0: hardwired zero in config 0, ordinary storage in config 1.
      drive(1'b0, 0, 1'b0, 0, 1'b1, 0, 32'hFFFF_FFFF, 4'hF);
      drive(1'b1, 0, 1'b0, 0, 1'b0, 0, 32'h0, 4'h0);
      idle();

      // Byte enables.
      drive(1'b0, 0, 1'b0, 0, 1'b1, 3, 32'h1122_3344, 4'hF);
      drive(1'b0, 0, 1'b0, 0, 1'b1, 3, 32'hAABB_CCDD, 4'b0101);
      drive(1'b1, 3, 1'b0, 0, 1'b0, 0, 32'h0, 4'h0);

      // Same-edge read/write collision, then a plain re-read.
      drive(1'b0, 0, 1'b0, 0, 1'b1, 7, 32'h0000_0010, 4'hF);
      drive(1'b1, 7, 1'b1, 7, 1'b1, 7, 32'h0000_0020, 4'hF);
      drive(1'b1, 7, 1'b0, 0, 1'b0, 0, 32'h0, 4'h0);

      // Dual-port read of one address, then hold on port A.
      drive(1'b0, 0, 1'b0, 0, 1'b1, 9, 32'h5A5A_5A5A, 4'hF);
      drive(1'b1, 9, 1'b1, 9, 1'b0, 0, 32'h0, 4'h0);
      drive(1'b0, 0, 1'b1, 9, 1'b1, 9, 32'h0, 4'h0);
      drive(1'b1, 9, 1'b0, 0, 1'b0, 0, 32'h0, 4'h0);
      idle();

      // Out-of-range address for the 24-register configuration.
      drive(1'b0, 0, 1'b0, 0, 1'b1, 30, 32'h1234_5678, 4'hF);
      drive(1'b1, 30, 1'b1, 23, 1'b0, 0, 32'h0, 4'h0);
      for (int a = 0; a < 24; a++) drive(1'b1, a, 1'b1, 23 - a, 1'b0, 0, 32'h0, 4'h0);
      idle();

      // Random traffic with frequent read/write address collisions.
      for (int n = 0; n < 600; n++) begin
         int aa, ab, wa;
         aa = int'($urandom_range(31, 0));
         ab = ($urandom_range(3, 0) == 0) ? aa : int'($urandom_range(31, 0));
         wa = ($urandom_range(2, 0) == 0) ? aa : int'($urandom_range(31, 0));
         drive(1'($urandom_range(1, 0)), aa, 1'($urandom_range(1, 0)), ab,
               1'($urandom_range(1, 0)), wa, $urandom, 4'($urandom_range(15, 0)));
         if (n == 300) reset_mid();
      end

      idle();
      idle();
      idle();
      for (int p = 0; p < 4; p++) chk($sformatf("drain p%0d", p), 32'(expq[p].size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
